// File: rtl/reu_dma_seq_p.sv
// -----------------------------------------------------------------------------
// reu_dma_seq_p -- REU DMA sequencer
//
// Owns the C64 address, REU address and length counters and steps through a
// stash / fetch / swap / verify transfer, one byte per PHI2 cycle (two cycles
// per byte for swap). Sits between the REU register file, the SDRAM
// controller and the C64 bus glue.
//
// Parameters
//   ADDR_W  REU address width
//   WRAP_W  REU address increments wrap mod 2^WRAP_W; bits above are held
//   LEN_W   length counter width; a start length of 0 means 2^LEN_W bytes
//
// Ports
//   PHI2, Reset             clock (rising edge) / async active-high reset
//   BA                      C64 bus available; low stalls the sequencer
//   Execute                 start strobe, honoured only in IDLE
//   XferType                00 stash, 01 fetch, 10 swap, 11 verify
//   FixCA, FixREUA          hold the respective address during the transfer
//   Autoload                restore counters at the end of the transfer
//   CAStart/REUAStart/LenStart  counter values loaded on Execute
//   CData, RData            C64 data bus / SDRAM read data
//   CDataOut, RDataOut      data to drive onto the C64 bus / into SDRAM
//   CA, REUA, Len           live counters
//   DMA, nWEDMA             C64 bus request / C64 write strobe (0 = write)
//   RAMRD, RAMWR            SDRAM read / write commands
//   Busy, XferEnd           transfer in progress / one-cycle end pulse
//   EndOfBlock, VerifyErr   sticky status, cleared on the next Execute
//
// Build option
//   REU_AUTOLOAD_EN  when defined, Autoload=1 at Execute makes the FINISH
//                    cycle reload CA/REUA/Len from shadowed start values.
//                    When undefined, Autoload is ignored.
// -----------------------------------------------------------------------------
module reu_dma_seq_p #(
   parameter int ADDR_W = 24,
   parameter int WRAP_W = 19,
   parameter int LEN_W  = 16
) (
   input  logic              PHI2,
   input  logic              Reset,
   input  logic              BA,
   input  logic              Execute,
   input  logic [1:0]        XferType,
   input  logic              FixCA,
   input  logic              FixREUA,
   input  logic              Autoload,
   input  logic [15:0]       CAStart,
   input  logic [ADDR_W-1:0] REUAStart,
   input  logic [LEN_W-1:0]  LenStart,
   input  logic [7:0]        CData,
   input  logic [7:0]        RData,
   output logic [7:0]        CDataOut,
   output logic [7:0]        RDataOut,
   output logic [15:0]       CA,
   output logic [ADDR_W-1:0] REUA,
   output logic [LEN_W-1:0]  Len,
   output logic              DMA,
   output logic              nWEDMA,
   output logic              RAMRD,
   output logic              RAMWR,
   output logic              Busy,
   output logic              XferEnd,
   output logic              EndOfBlock,
   output logic              VerifyErr
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_SWAP2, S_FINISH} state_t;

   localparam logic [1:0] XT_STASH  = 2'b00;
   localparam logic [1:0] XT_FETCH  = 2'b01;
   localparam logic [1:0] XT_SWAP   = 2'b10;
   localparam logic [1:0] XT_VERIFY = 2'b11;

   // Low WRAP_W bits take part in the increment; the bank bits above stay put.
   localparam logic [ADDR_W-1:0] WRAP_MASK = ~({ADDR_W{1'b1}} << WRAP_W);
   localparam logic [ADDR_W-1:0] REUA_ONE  = 1;
   localparam logic [LEN_W-1:0]  LEN_ONE   = 1;

   state_t            state_q;
   logic [15:0]       ca_q;
   logic [ADDR_W-1:0] reua_q;
   logic [LEN_W-1:0]  len_q;
   logic              eob_q;
   logic              verr_q;
   logic [7:0]        swc_q;   // C64 byte captured in the swap read cycle
   logic [7:0]        swr_q;   // REU byte captured in the swap read cycle

   logic [15:0]       ca_d;
   logic [ADDR_W-1:0] reua_d;
   logic [LEN_W-1:0]  len_d;
   logic              byte_done;

`ifdef REU_AUTOLOAD_EN
   logic              autold_q;
   logic [15:0]       ca_sh_q;
   logic [ADDR_W-1:0] reua_sh_q;
   logic [LEN_W-1:0]  len_sh_q;
`else
   // Autoload has no effect in this build.
   logic              unused_autoload;
   assign unused_autoload = Autoload;
`endif

   // A byte completes on every unstalled XFER cycle except the swap read
   // half, which finishes in SWAP2.
   assign byte_done = BA && (((state_q == S_XFER) && (XferType != XT_SWAP)) ||
                             (state_q == S_SWAP2));

   assign ca_d   = FixCA   ? ca_q   : ca_q + 16'd1;
   assign reua_d = FixREUA ? reua_q
                           : ((reua_q & ~WRAP_MASK) | ((reua_q + REUA_ONE) & WRAP_MASK));
   assign len_d  = len_q - LEN_ONE;   // 0 wraps to all ones

   always_ff @(posedge PHI2 or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         ca_q    <= '0;
         reua_q  <= '0;
         len_q   <= '0;
         eob_q   <= 1'b0;
         verr_q  <= 1'b0;
         swc_q   <= '0;
         swr_q   <= '0;
`ifdef REU_AUTOLOAD_EN
         autold_q  <= 1'b0;
         ca_sh_q   <= '0;
         reua_sh_q <= '0;
         len_sh_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Execute) begin
                  ca_q    <= CAStart;
                  reua_q  <= REUAStart;
                  len_q   <= LenStart;
                  eob_q   <= 1'b0;
                  verr_q  <= 1'b0;
`ifdef REU_AUTOLOAD_EN
                  autold_q  <= Autoload;
                  ca_sh_q   <= CAStart;
                  reua_sh_q <= REUAStart;
                  len_sh_q  <= LenStart;
`endif
                  state_q <= S_XFER;
               end
            end
            S_XFER: begin
               if (BA) begin
                  if (XferType == XT_SWAP) begin
                     swc_q   <= CData;
                     swr_q   <= RData;
                     state_q <= S_SWAP2;
                  end else if ((XferType == XT_VERIFY) && (RData != CData)) begin
                     verr_q  <= 1'b1;
                     state_q <= S_FINISH;
                  end
               end
            end
            S_SWAP2: begin
               if (BA) state_q <= S_XFER;
            end
            S_FINISH: begin
`ifdef REU_AUTOLOAD_EN
               if (autold_q) begin
                  ca_q   <= ca_sh_q;
                  reua_q <= reua_sh_q;
                  len_q  <= len_sh_q;
               end
`endif
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // Counters advance even for a mismatching verify byte; the last
         // byte leaves Len at 1.
         if (byte_done) begin
            ca_q   <= ca_d;
            reua_q <= reua_d;
            if (len_q == LEN_ONE) begin
               eob_q   <= 1'b1;
               state_q <= S_FINISH;
            end else begin
               len_q <= len_d;
            end
         end
      end
   end

   // Bus and SDRAM commands decode from the registered state, gated by BA.
   always_comb begin
      RAMRD    = 1'b0;
      RAMWR    = 1'b0;
      nWEDMA   = 1'b1;
      CDataOut = '0;
      RDataOut = '0;
      if (BA) begin
         if (state_q == S_XFER) begin
            case (XferType)
               XT_STASH: begin
                  RAMWR    = 1'b1;
                  RDataOut = CData;
               end
               XT_FETCH: begin
                  RAMRD    = 1'b1;
                  nWEDMA   = 1'b0;
                  CDataOut = RData;
               end
               default: RAMRD = 1'b1;   // swap read half and verify
            endcase
         end else if (state_q == S_SWAP2) begin
            RAMWR    = 1'b1;
            RDataOut = swc_q;
            nWEDMA   = 1'b0;
            CDataOut = swr_q;
         end
      end
   end

   assign DMA        = (state_q == S_XFER) || (state_q == S_SWAP2);
   assign Busy       = (state_q != S_IDLE);
   assign XferEnd    = (state_q == S_FINISH);
   assign CA         = ca_q;
   assign REUA       = reua_q;
   assign Len        = len_q;
   assign EndOfBlock = eob_q;
   assign VerifyErr  = verr_q;

endmodule

// File: tb/tb_reu_dma_seq_p.sv
// -----------------------------------------------------------------------------
// tb_reu_dma_seq_p -- directed bench for reu_dma_seq_p (LEN_W=4 so that the
// Len==0 case runs a full 16-byte block).
// -----------------------------------------------------------------------------
module tb_reu_dma_seq_p;
   localparam int ADDR_W = 24;
   localparam int WRAP_W = 19;
   localparam int LEN_W  = 4;

   logic              PHI2 = 1'b0;
   logic              Reset = 1'b1;
   logic              BA = 1'b0;
   logic              Execute = 1'b0;
   logic [1:0]        XferType = 2'b00;
   logic              FixCA = 1'b0;
   logic              FixREUA = 1'b0;
   logic              Autoload = 1'b0;
   logic [15:0]       CAStart = '0;
   logic [ADDR_W-1:0] REUAStart = '0;
   logic [LEN_W-1:0]  LenStart = '0;
   logic [7:0]        CData = '0;
   logic [7:0]        RData = '0;
   logic [7:0]        CDataOut, RDataOut;
   logic [15:0]       CA;
   logic [ADDR_W-1:0] REUA;
   logic [LEN_W-1:0]  Len;
   logic              DMA, nWEDMA, RAMRD, RAMWR, Busy, XferEnd, EndOfBlock, VerifyErr;

   reu_dma_seq_p #(.ADDR_W(ADDR_W), .WRAP_W(WRAP_W), .LEN_W(LEN_W)) dut (
      .PHI2(PHI2), .Reset(Reset), .BA(BA), .Execute(Execute), .XferType(XferType),
      .FixCA(FixCA), .FixREUA(FixREUA), .Autoload(Autoload),
      .CAStart(CAStart), .REUAStart(REUAStart), .LenStart(LenStart),
      .CData(CData), .RData(RData), .CDataOut(CDataOut), .RDataOut(RDataOut),
      .CA(CA), .REUA(REUA), .Len(Len), .DMA(DMA), .nWEDMA(nWEDMA),
      .RAMRD(RAMRD), .RAMWR(RAMWR), .Busy(Busy), .XferEnd(XferEnd),
      .EndOfBlock(EndOfBlock), .VerifyErr(VerifyErr)
   );

   always #5 PHI2 = ~PHI2;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge PHI2);
   endtask

   // {DMA,nWEDMA,RAMRD,RAMWR,Busy,XferEnd,EndOfBlock,VerifyErr}
   function automatic logic [7:0] ctl();
      return {DMA, nWEDMA, RAMRD, RAMWR, Busy, XferEnd, EndOfBlock, VerifyErr};
   endfunction

   function automatic logic [59:0] dat();
      return {CA, REUA, Len, CDataOut, RDataOut};
   endfunction

   typedef struct {
      logic        exe;
      logic        ba;
      logic [1:0]  xt;
      logic [7:0]  cd;
      logic [7:0]  rd;
      logic [7:0]  ctl;
      logic [15:0] ca;
      logic [23:0] reua;
      logic [3:0]  len;
      logic [7:0]  cout;
      logic [7:0]  rout;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #100000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int nwe, dma_lo, act, wr, camov, seen;
      logic [1:0] bapat [5];

      // Stash CA=0x1000 REUA=0x07FFFE Len=4: REUA wraps inside the 512 KB bank.
      tbl[0] = '{1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 8'b0100_0000, 16'h0000, 24'h000000, 4'd0, 8'h00, 8'h00};
      tbl[1] = '{1'b0, 1'b1, 2'b00, 8'h51, 8'h99, 8'b1101_1000, 16'h1000, 24'h07FFFE, 4'd4, 8'h00, 8'h51};
      tbl[2] = '{1'b0, 1'b1, 2'b00, 8'h52, 8'h99, 8'b1101_1000, 16'h1001, 24'h07FFFF, 4'd3, 8'h00, 8'h52};
      tbl[3] = '{1'b0, 1'b1, 2'b00, 8'h53, 8'h99, 8'b1101_1000, 16'h1002, 24'h000000, 4'd2, 8'h00, 8'h53};
      tbl[4] = '{1'b0, 1'b1, 2'b00, 8'h54, 8'h99, 8'b1101_1000, 16'h1003, 24'h000001, 4'd1, 8'h00, 8'h54};
      tbl[5] = '{1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 8'b0100_1110, 16'h1004, 24'h000002, 4'd1, 8'h00, 8'h00};
      tbl[6] = '{1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 8'b0100_0010, 16'h1004, 24'h000002, 4'd1, 8'h00, 8'h00};

      // Reset state
      tick(); tick(); #1;
      chk("reset_ctl", 64'(ctl()), 64'(8'b0100_0000));
      chk("reset_dat", 64'(dat()), 64'd0);

      // Table-driven stash
      CAStart = 16'h1000; REUAStart = 24'h07FFFE; LenStart = 4'd4;
      for (int i = 0; i < 7; i++) begin
         tick();
         Reset = 1'b0;
         Execute = tbl[i].exe; BA = tbl[i].ba; XferType = tbl[i].xt;
         CData = tbl[i].cd; RData = tbl[i].rd;
         #1;
         chk($sformatf("stash_ctl[%0d]", i), 64'(ctl()), 64'(tbl[i].ctl));
         chk($sformatf("stash_dat[%0d]", i), 64'(dat()),
             64'({tbl[i].ca, tbl[i].reua, tbl[i].len, tbl[i].cout, tbl[i].rout}));
      end

      // Fetch Len=3 with a 2-cycle BA stall; Execute held high while busy
      tick();
      Execute = 1'b1; XferType = 2'b01; BA = 1'b1;
      CAStart = 16'h2000; REUAStart = 24'h000100; LenStart = 4'd3;
      bapat[0] = 2'd1; bapat[1] = 2'd0; bapat[2] = 2'd0; bapat[3] = 2'd1; bapat[4] = 2'd1;
      nwe = 0; dma_lo = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         CAStart = 16'hFFFF;
         BA = bapat[i][0];
         RData = 8'(8'h30 + i);
         #1;
         if (!DMA) dma_lo++;
         if (!nWEDMA) nwe++;
         if (BA) chk($sformatf("fetch_cout[%0d]", i), 64'(CDataOut), 64'(RData));
         else    chk($sformatf("fetch_stall_cmd[%0d]", i), 64'({RAMRD, nWEDMA}), 64'(2'b01));
         if (i == 2) chk("fetch_frozen", 64'({CA, Len}), 64'({16'h2001, 4'd2}));
      end
      tick();
      Execute = 1'b0; BA = 1'b1;
      #1;
      chk("fetch_fin", 64'({DMA, XferEnd, EndOfBlock}), 64'(3'b011));
      chk("fetch_cnt", 64'({CA, REUA, Len}), 64'({16'h2003, 24'h000103, 4'd1}));
      chk("fetch_nwe_cycles", 64'(nwe), 64'd3);
      chk("fetch_dma_drop", 64'(dma_lo), 64'd0);

      // Swap Len=2, upper REU bank bits held across the wrap
      tick();
      Execute = 1'b1; XferType = 2'b10;
      CAStart = 16'h3000; REUAStart = 24'hA7FFFF; LenStart = 4'd2;
      act = 0;
      tick(); Execute = 1'b0; CData = 8'hAA; RData = 8'h11; #1;
      act += int'(DMA);
      chk("swap_rd1", 64'({RAMRD, RAMWR, nWEDMA}), 64'(3'b101));
      tick(); CData = 8'hEE; RData = 8'hEE; #1;
      act += int'(DMA);
      chk("swap_wr1", 64'({RAMRD, RAMWR, nWEDMA, RDataOut, CDataOut}), 64'({3'b010, 8'hAA, 8'h11}));
      tick(); CData = 8'hBB; RData = 8'h22; #1;
      act += int'(DMA);
      chk("swap_rd2", 64'({RAMRD, RAMWR, nWEDMA, CA, REUA}), 64'({3'b101, 16'h3001, 24'hA00000}));
      tick(); CData = 8'hEE; RData = 8'hEE; #1;
      act += int'(DMA);
      chk("swap_wr2", 64'({RAMRD, RAMWR, nWEDMA, RDataOut, CDataOut}), 64'({3'b010, 8'hBB, 8'h22}));
      tick(); #1;
      act += int'(DMA);
      chk("swap_fin", 64'({XferEnd, EndOfBlock, CA, REUA, Len}), 64'({2'b11, 16'h3002, 24'hA00001, 4'd1}));
      chk("swap_active_cycles", 64'(act), 64'd4);

      // Verify Len=5, mismatch on byte 3
      tick();
      Execute = 1'b1; XferType = 2'b11;
      CAStart = 16'h4000; REUAStart = 24'h000200; LenStart = 4'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         Execute = 1'b0; CData = 8'h5A; RData = (i == 2) ? 8'h5B : 8'h5A;
         #1;
         if (i == 2) chk("verify_pre", 64'({RAMRD, VerifyErr, DMA}), 64'(3'b101));
      end
      tick(); #1;
      chk("verify_mid_err", 64'({VerifyErr, EndOfBlock, DMA, XferEnd, CA, Len}),
          64'({4'b1001, 16'h4003, 4'd2}));

      // Verify mismatch on the last byte, REU address fixed
      tick();
      Execute = 1'b1; FixREUA = 1'b1;
      CAStart = 16'h4100; REUAStart = 24'h000250; LenStart = 4'd1;
      tick(); Execute = 1'b0; CData = 8'h01; RData = 8'h02; #1;
      tick(); #1;
      chk("verify_last_err", 64'({VerifyErr, EndOfBlock, XferEnd, CA, REUA}),
          64'({3'b111, 16'h4101, 24'h000250}));
      FixREUA = 1'b0;

      // Len=0 means 16 bytes at LEN_W=4; CA fixed; Autoload requested
      tick();
      Execute = 1'b1; XferType = 2'b00; FixCA = 1'b1; Autoload = 1'b1;
      CAStart = 16'h5000; REUAStart = 24'h000300; LenStart = 4'd0;
      wr = 0; camov = 0; seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         tick();
         Execute = 1'b0; CData = 8'(i);
         #1;
         wr += int'(RAMWR);
         if (CA != 16'h5000) camov++;
         if (XferEnd) seen = 1;
      end
      chk("len0_end_seen", 64'(seen), 64'd1);
      chk("len0_bytes", 64'(wr), 64'd16);
      chk("len0_ca_fixed", 64'(camov), 64'd0);
      tick();
      Autoload = 1'b0; FixCA = 1'b0;
      #1;
`ifdef REU_AUTOLOAD_EN
      chk("len0_restore", 64'({CA, REUA, Len, EndOfBlock}), 64'({16'h5000, 24'h000300, 4'd0, 1'b1}));
`else
      chk("len0_final", 64'({CA, REUA, Len, EndOfBlock}), 64'({16'h5000, 24'h000310, 4'd1, 1'b1}));
`endif

      // Reset asserted in SWAP2, with Execute held high during reset
      tick();
      Execute = 1'b1; XferType = 2'b10;
      CAStart = 16'h3100; REUAStart = 24'h000400; LenStart = 4'd2;
      tick(); Execute = 1'b0; CData = 8'hC1; RData = 8'hD1; #1;
      tick(); #1;
      chk("rst_in_swap2", 64'({RAMWR, nWEDMA, RDataOut}), 64'({2'b10, 8'hC1}));
      Reset = 1'b1; Execute = 1'b1;
      #1;
      chk("rst_async_ctl", 64'(ctl()), 64'(8'b0100_0000));
      chk("rst_async_dat", 64'(dat()), 64'd0);
      tick(); tick(); #1;
      chk("rst_wins_exec", 64'(Busy), 64'd0);
      tick();
      Reset = 1'b0; Execute = 1'b1; XferType = 2'b00;
      CAStart = 16'h6000; REUAStart = 24'h000500; LenStart = 4'd1;
      tick(); Execute = 1'b0; CData = 8'h77; #1;
      chk("post_rst_xfer", 64'({DMA, RAMWR, RDataOut, CA, REUA, Len, EndOfBlock}),
          64'({2'b11, 8'h77, 16'h6000, 24'h000500, 4'd1, 1'b0}));
      tick(); #1;
      chk("post_rst_fin", 64'({XferEnd, EndOfBlock, CA, REUA}), 64'({2'b11, 16'h6001, 24'h000501}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
